// File: rtl/store_buffer_pkg.sv
// Shared types and width constants for the posted-write store buffer.
package store_buffer_pkg;

    // Default geometry of the buffer
    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;

    // Data memory port widths; the buffer sits directly in front of it
    localparam int MEM_AW   = 32;
    localparam int MEM_DW   = 32;

    // One pending store
    typedef struct packed {
        logic              valid;
        logic [SB_AW-1:0]  adr;
        logic [SB_DW-1:0]  data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_cam.sv
// Youngest-match search over the pending stores.
// Entries are scanned oldest (head) to youngest, so a later match overrides
// an earlier one and the youngest matching store supplies the data.
module store_buffer_cam
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int PW   = $clog2(DEPTH)
) (
    input  sb_entry_t          entries [DEPTH],
    input  logic [PW-1:0]      head,
    input  logic [SB_AW-1:0]   key,
    output logic               hit,
    output logic [SB_DW-1:0]   data
);

    // Scan from head towards tail; the last matching entry wins
    always_comb begin : scan
        logic [PW-1:0] idx_s;
        hit   = 1'b0;
        data  = '0;
        idx_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head + PW'(i);
            if (entries[idx_s].valid && (entries[idx_s].adr == key)) begin
                hit  = 1'b1;
                data = entries[idx_s].data;
            end else begin
                hit  = hit;
                data = data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between EX/MEM and the data memory.
// Stores queue in a small FIFO and drain when the memory port is free;
// loads forward from the youngest matching pending store or go to memory.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic [AW-1:0]  CpuAdr,
    input  logic [DW-1:0]  CpuWrd,
    input  logic           CpuWr,
    input  logic           CpuRd,
    input  logic           Sync,
    input  logic [DW-1:0]  MemRd,
    output logic [AW-1:0]  Adr,
    output logic [DW-1:0]  Wrd,
    output logic           MemWr,
    output logic           MemR,
    output logic [DW-1:0]  LdData,
    output logic           LdFwd,
    output logic           Empty,
    output logic [CW-1:0]  Count
);

    sb_entry_t         entry_r [DEPTH];
    logic [PW-1:0]     head_r;
    logic [PW-1:0]     tail_r;
    logic [CW-1:0]     count_r;
    logic              empty_r;
    logic              ld_fwd_r;
    logic [DW-1:0]     fwd_data_r;

    logic              rd_s;
    logic              push_s;
    logic              pop_s;
    logic              hit_s;
    logic              miss_s;
    logic              full_s;
    logic [DW-1:0]     cam_data_s;

    // A simultaneous store request wins; the load is dropped
    assign rd_s   = CpuRd & ~CpuWr;
    assign push_s = CpuWr;
    assign full_s = (count_r == CW'(DEPTH));
    assign miss_s = rd_s & ~hit_s;

    store_buffer_cam #(.DEPTH(DEPTH)) u_cam (
        .entries (entry_r),
        .head    (head_r),
        .key     (CpuAdr),
        .hit     (hit_s),
        .data    (cam_data_s)
    );

    // Port arbiter: decide whether the head drains and drive the memory port
    always_comb begin
        pop_s = 1'b0;
        Adr   = '0;
        Wrd   = '0;
        if (!empty_r) begin
            pop_s = (!CpuWr && !CpuRd)     // idle cycle
                  || (rd_s && hit_s)       // forwarded load leaves port free
                  || (push_s && full_s)    // make room for the incoming store
                  || (Sync && !miss_s);    // forced drain unless a miss owns the port
        end else begin
            pop_s = 1'b0;
        end
        if (miss_s) begin
            Adr = CpuAdr;
        end else if (pop_s) begin
            Adr = entry_r[head_r].adr;
            Wrd = entry_r[head_r].data;
        end else begin
            Adr = '0;
            Wrd = '0;
        end
    end

    assign MemWr  = pop_s;
    assign MemR   = miss_s;
    assign Empty  = empty_r;
    assign Count  = count_r;
    assign LdFwd  = ld_fwd_r;
    assign LdData = ld_fwd_r ? fwd_data_r : MemRd;

    // FIFO storage, pointers and occupancy; a push to the slot being
    // popped (full case) is written last so the new entry survives
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '0;
            end
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            empty_r <= 1'b1;
        end else begin
            if (pop_s) begin
                entry_r[head_r].valid <= 1'b0;
                head_r                <= head_r + PW'(1);
            end
            if (push_s) begin
                entry_r[tail_r] <= '{valid: 1'b1, adr: CpuAdr, data: CpuWrd};
                tail_r          <= tail_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10: begin
                    count_r <= count_r + CW'(1);
                    empty_r <= 1'b0;
                end
                2'b01: begin
                    count_r <= count_r - CW'(1);
                    empty_r <= (count_r == CW'(1));
                end
                default: begin
                    count_r <= count_r;
                    empty_r <= empty_r;
                end
            endcase
        end
    end

    // Load-return register: captured only on load cycles, held otherwise
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ld_fwd_r   <= 1'b0;
            fwd_data_r <= '0;
        end else if (rd_s) begin
            ld_fwd_r   <= hit_s;
            fwd_data_r <= cam_data_s;
        end else begin
            ld_fwd_r   <= ld_fwd_r;
            fwd_data_r <= fwd_data_r;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small registered-read memory model.
module tb_store_buffer;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] CpuAdr;
    logic [31:0] CpuWrd;
    logic        CpuWr;
    logic        CpuRd;
    logic        Sync;
    logic [31:0] MemRd;
    logic [31:0] Adr;
    logic [31:0] Wrd;
    logic        MemWr;
    logic        MemR;
    logic [31:0] LdData;
    logic        LdFwd;
    logic        Empty;
    logic [2:0]  Count;

    int checks;
    int errors;

    logic [31:0] mem [64];

    store_buffer dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .CpuAdr (CpuAdr),
        .CpuWrd (CpuWrd),
        .CpuWr  (CpuWr),
        .CpuRd  (CpuRd),
        .Sync   (Sync),
        .MemRd  (MemRd),
        .Adr    (Adr),
        .Wrd    (Wrd),
        .MemWr  (MemWr),
        .MemR   (MemR),
        .LdData (LdData),
        .LdFwd  (LdFwd),
        .Empty  (Empty),
        .Count  (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Data memory: write at posedge, registered read; word i holds i after reset
    always @(posedge Clk) begin
        if (!Rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
            MemRd <= 32'h0;
        end else begin
            if (MemWr) mem[Adr[5:0]] <= Wrd;
            if (MemR)  MemRd <= mem[Adr[5:0]];
        end
    end

    typedef struct {
        logic        wr, rd, sync;
        logic [31:0] adr, wrd;
        logic        e_memwr, e_memr;
        logic [31:0] e_adr, e_wrd;
        logic [2:0]  e_count;
        logic        chk_ld;
        logic        e_fwd;
        logic [31:0] e_ld;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic wr, input logic rd, input logic sync,
                       input logic [31:0] adr, input logic [31:0] wrd,
                       input logic e_memwr, input logic e_memr,
                       input logic [31:0] e_adr, input logic [31:0] e_wrd,
                       input logic [2:0] e_count, input logic chk_ld,
                       input logic e_fwd, input logic [31:0] e_ld);
        vec_t v;
        v.wr = wr; v.rd = rd; v.sync = sync; v.adr = adr; v.wrd = wrd;
        v.e_memwr = e_memwr; v.e_memr = e_memr; v.e_adr = e_adr; v.e_wrd = e_wrd;
        v.e_count = e_count; v.chk_ld = chk_ld; v.e_fwd = e_fwd; v.e_ld = e_ld;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic sync,
                         input logic [31:0] adr, input logic [31:0] wrd);
        CpuWr = wr; CpuRd = rd; Sync = sync; CpuAdr = adr; CpuWrd = wrd;
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        Rst_n  = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h55, 32'h66);

        // Reset held with a store request pending: nothing may enter the buffer
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            chk("rst_empty", {31'h0, Empty}, 32'h1);
            chk("rst_count", {29'h0, Count}, 32'h0);
            chk("rst_memwr", {31'h0, MemWr}, 32'h0);
            chk("rst_ldfwd", {31'h0, LdFwd}, 32'h0);
        end
        @(negedge Clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("idle_memwr", {31'h0, MemWr}, 32'h0);
        chk("idle_adr", Adr, 32'h0);
        @(posedge Clk); #1;
        chk("post_rst_count", {29'h0, Count}, 32'h0);

        //  wr rd sy  adr     wrd      mw mr eadr    ewrd     cnt ld fwd eld
        add(1, 0, 0, 32'd5,  32'hAA,  0, 0, 32'd0,  32'h0,   1,  0, 0, 32'h0);
        add(0, 0, 0, 32'd0,  32'h0,   1, 0, 32'd5,  32'hAA,  0,  0, 0, 32'h0);
        add(0, 1, 0, 32'd5,  32'h0,   0, 1, 32'd5,  32'h0,   0,  1, 0, 32'hAA);
        add(1, 0, 0, 32'd1,  32'h101, 0, 0, 32'd0,  32'h0,   1,  0, 0, 32'h0);
        add(1, 0, 0, 32'd2,  32'h102, 0, 0, 32'd0,  32'h0,   2,  0, 0, 32'h0);
        add(1, 0, 0, 32'd3,  32'h103, 0, 0, 32'd0,  32'h0,   3,  0, 0, 32'h0);
        add(1, 0, 0, 32'd4,  32'h104, 0, 0, 32'd0,  32'h0,   4,  0, 0, 32'h0);
        add(1, 0, 0, 32'd5,  32'h105, 1, 0, 32'd1,  32'h101, 4,  0, 0, 32'h0);
        add(0, 0, 0, 32'd0,  32'h0,   1, 0, 32'd2,  32'h102, 3,  0, 0, 32'h0);
        add(0, 0, 0, 32'd0,  32'h0,   1, 0, 32'd3,  32'h103, 2,  0, 0, 32'h0);
        add(0, 0, 0, 32'd0,  32'h0,   1, 0, 32'd4,  32'h104, 1,  0, 0, 32'h0);
        add(0, 0, 0, 32'd0,  32'h0,   1, 0, 32'd5,  32'h105, 0,  0, 0, 32'h0);
        add(1, 0, 0, 32'd7,  32'h11,  0, 0, 32'd0,  32'h0,   1,  0, 0, 32'h0);
        add(1, 0, 0, 32'd7,  32'h22,  0, 0, 32'd0,  32'h0,   2,  0, 0, 32'h0);
        add(0, 1, 0, 32'd7,  32'h0,   1, 0, 32'd7,  32'h11,  1,  1, 1, 32'h22);
        add(0, 0, 0, 32'd0,  32'h0,   1, 0, 32'd7,  32'h22,  0,  1, 1, 32'h22);
        add(1, 0, 0, 32'd3,  32'h33,  0, 0, 32'd0,  32'h0,   1,  0, 0, 32'h0);
        add(0, 1, 0, 32'd9,  32'h0,   0, 1, 32'd9,  32'h0,   1,  1, 0, 32'h9);
        add(0, 0, 0, 32'd0,  32'h0,   1, 0, 32'd3,  32'h33,  0,  0, 0, 32'h0);
        add(0, 1, 0, 32'd3,  32'h0,   0, 1, 32'd3,  32'h0,   0,  1, 0, 32'h33);
        add(1, 1, 0, 32'd8,  32'h88,  0, 0, 32'd0,  32'h0,   1,  1, 0, 32'h33);
        add(1, 0, 1, 32'd10, 32'hA0,  1, 0, 32'd8,  32'h88,  1,  0, 0, 32'h0);
        add(0, 1, 1, 32'd11, 32'h0,   0, 1, 32'd11, 32'h0,   1,  1, 0, 32'd11);
        add(0, 1, 1, 32'd10, 32'h0,   1, 0, 32'd10, 32'hA0,  0,  1, 1, 32'hA0);

        foreach (vq[i]) begin
            drive(vq[i].wr, vq[i].rd, vq[i].sync, vq[i].adr, vq[i].wrd);
            @(negedge Clk);
            chk($sformatf("v%0d_memwr", i), {31'h0, MemWr}, {31'h0, vq[i].e_memwr});
            chk($sformatf("v%0d_memr", i),  {31'h0, MemR},  {31'h0, vq[i].e_memr});
            chk($sformatf("v%0d_adr", i),   Adr, vq[i].e_adr);
            chk($sformatf("v%0d_wrd", i),   Wrd, vq[i].e_wrd);
            @(posedge Clk); #1;
            chk($sformatf("v%0d_count", i), {29'h0, Count}, {29'h0, vq[i].e_count});
            chk($sformatf("v%0d_empty", i), {31'h0, Empty}, {31'h0, (vq[i].e_count == 3'd0)});
            if (vq[i].chk_ld) begin
                chk($sformatf("v%0d_ldfwd", i),  {31'h0, LdFwd}, {31'h0, vq[i].e_fwd});
                chk($sformatf("v%0d_lddata", i), LdData, vq[i].e_ld);
            end
        end

        // Sync drain of three entries in FIFO order
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'(20 + i), 32'(32'h200 + i));
            @(posedge Clk); #1;
        end
        chk("sync_pre_count", {29'h0, Count}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
            @(negedge Clk);
            chk($sformatf("sync%0d_memwr", i), {31'h0, MemWr}, 32'h1);
            chk($sformatf("sync%0d_adr", i), Adr, 32'(20 + i));
            chk($sformatf("sync%0d_wrd", i), Wrd, 32'(32'h200 + i));
            @(posedge Clk); #1;
            chk($sformatf("sync%0d_count", i), {29'h0, Count}, 32'(2 - i));
        end
        chk("sync_empty", {31'h0, Empty}, 32'h1);
        @(negedge Clk);
        chk("sync_done_memwr", {31'h0, MemWr}, 32'h0);

        // Reset pulse in the middle of a forced drain
        @(posedge Clk); #1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'(30 + i), 32'(32'h300 + i));
            @(posedge Clk); #1;
        end
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        @(negedge Clk);
        chk("mid_memwr", {31'h0, MemWr}, 32'h1);
        chk("mid_adr", Adr, 32'd30);
        @(posedge Clk); #1;
        chk("mid_count", {29'h0, Count}, 32'd2);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("async_count", {29'h0, Count}, 32'h0);
        chk("async_empty", {31'h0, Empty}, 32'h1);
        chk("async_memwr", {31'h0, MemWr}, 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk($sformatf("post%0d_memwr", i), {31'h0, MemWr}, 32'h0);
            chk($sformatf("post%0d_count", i), {29'h0, Count}, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
